// File: rtl/mux_pkg.sv
// Shared constants and the select-width helper for the pipelined N-to-1 mux.
package mux_pkg;

  localparam int MUX_DEFAULT_SIZE = 32;

  // Width needed to index n items; never below 1 so a select port always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational N-to-1 channel selector; out-of-range selects fall back to channel 0.
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int SIZE = MUX_DEFAULT_SIZE,
  parameter int CHANNELS = 3,
  localparam int SEL_W = clog2(CHANNELS)
) (
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]         select_i,
  output logic [SIZE-1:0]          data_o
);

  // Channel 0 is the default, so any select with no matching channel
  // (only possible when CHANNELS is not a power of two) lands there.
  always_comb begin
    data_o = data_i[0 +: SIZE];
    for (int k = 1; k < CHANNELS; k++) begin
      if (int'(select_i) == k) data_o = data_i[k*SIZE +: SIZE];
    end
  end

endmodule

// File: rtl/mux_n_to_1_pipe.sv
// Registered N-to-1 mux with flush/stall control. Defining MUX_SEL_ERR_EN adds
// the sticky out-of-range select flag sel_err_o.
module mux_n_to_1_pipe
  import mux_pkg::*;
#(
  parameter int SIZE = MUX_DEFAULT_SIZE,
  parameter int CHANNELS = 3,
  localparam int SEL_W = clog2(CHANNELS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [CHANNELS*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]         select_i,
  input  logic                     valid_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [SIZE-1:0]          data_o,
  output logic                     valid_o
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                     sel_err_o
`endif
);

  logic [SIZE-1:0] sel_data;

  mux_nto1_comb #(
    .SIZE(SIZE),
    .CHANNELS(CHANNELS)
  ) u_comb (
    .data_i(data_i),
    .select_i(select_i),
    .data_o(sel_data)
  );

  // Handshake: valid_i qualifies the selected word for one cycle and there is no
  // ready; stall_i freezes the output stage, flush_i empties it and wins over stall_i.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (valid_i) data_o <= sel_data;
      valid_o <= valid_i;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_oor;

  assign sel_oor = (int'(select_i) >= CHANNELS);

  // Sticky until reset; a flush deliberately leaves it set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_err_o <= 1'b0;
    end else if (!flush_i && !stall_i && valid_i && sel_oor) begin
      sel_err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mux_n_to_1_pipe.md
MUX_N_TO_1_PIPE -- requirements
Module: mux_n_to_1_pipe

Interface
REQ-001 SHALL have parameter SIZE, default 32: data width per channel, minimum 1.
REQ-002 SHALL have parameter CHANNELS, default 3: number of input channels, minimum 2.
REQ-003 SHALL have derived parameter SEL_W = ceil(log2(CHANNELS)), minimum 1: select width.
REQ-004 clk_i  input  1: single clock, all state updates on its rising edge.
REQ-005 rst_i  input  1: reset, asynchronous, active-low.
REQ-006 data_i  input  CHANNELS*SIZE: packed channels, channel k at bits [k*SIZE +: SIZE].
REQ-007 select_i  input  SEL_W: channel index.
REQ-008 valid_i  input  1: input word valid this cycle.
REQ-009 stall_i  input  1: hold output register.
REQ-010 flush_i  input  1: clear output register.
REQ-011 data_o  output  SIZE: registered selected data.
REQ-012 valid_o  output  1: registered valid.
REQ-013 sel_err_o  output  1: sticky out-of-range-select flag (present only with MUX_SEL_ERR_EN).

Function
REQ-014 Selection SHALL be channel select_i when select_i < CHANNELS, else channel 0.
REQ-015 Latency SHALL be exactly one clock: inputs sampled on edge N appear on data_o/valid_o after edge N.
REQ-016 Priority per edge SHALL be flush_i > stall_i > normal update.
REQ-017 flush_i=1: data_o <= 0, valid_o <= 0, regardless of stall_i and valid_i.
REQ-018 stall_i=1, flush_i=0: data_o and valid_o hold; inputs ignored.
REQ-019 Normal, valid_i=1: data_o <= selected channel, valid_o <= 1.
REQ-020 Normal, valid_i=0: data_o holds previous value, valid_o <= 0.
REQ-021 No combinational path SHALL exist from any input to data_o or valid_o.
REQ-022 When CHANNELS is a power of two, every select_i value is in range; out-of-range logic SHALL reduce to constant.

Reset
REQ-023 rst_i low SHALL immediately force data_o=0, valid_o=0, sel_err_o=0, independent of clk_i.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override both; first edge after release SHALL follow REQ-016..020.

Configuration
REQ-025 Macro MUX_SEL_ERR_EN defined: sel_err_o present; set to 1 on any edge with flush_i=0, stall_i=0, valid_i=1, select_i >= CHANNELS; cleared only by reset; flush does not clear it.
REQ-026 Macro MUX_SEL_ERR_EN undefined: sel_err_o port and its logic SHALL be absent; REQ-014 fallback unchanged.

Structure
REQ-027 Shared package mux_pkg SHALL hold the clog2 helper function and default constant MUX_DEFAULT_SIZE=32.
REQ-028 Combinational selection SHALL be sub-module mux_nto1_comb (params SIZE, CHANNELS); mux_n_to_1_pipe adds the register stage, control priority and error flag.

Verification
REQ-029 SIZE=32, CHANNELS=3; data_i ch0=0x11, ch1=0x22, ch2=0x33; select_i 0,1,2 with valid_i=1 on consecutive edges -> data_o 0x11,0x22,0x33 one cycle later each, valid_o=1.
REQ-030 Same config, select_i=3, valid_i=1 -> data_o=0x11 next cycle; with MUX_SEL_ERR_EN sel_err_o=1 and stays 1 through later flush.
REQ-031 Load 0x22, then stall_i=1 for 3 cycles while select_i=2 -> data_o stays 0x22, valid_o stays 1; release -> 0x33 next edge.
REQ-032 stall_i=1 and flush_i=1 same edge -> data_o=0, valid_o=0.
REQ-033 Load 0x33, then valid_i=0 with select_i=0 -> data_o stays 0x33, valid_o=0.
REQ-034 rst_i low between clock edges while valid_o=1 -> data_o=0, valid_o=0, sel_err_o=0 immediately, before next edge.
